gnn_aggr_xchg: RTL and testbench

Neighbourhood-aggregation exchange for the GNN datapath. It collects the post-ReLU hidden features (y4..y7, 15-bit) produced by the per-node layer-1 multiply stage of every graph node. It then forms, per node, the sum of its own features and those of its adjacent nodes. The aggregates (17-bit) are streamed back to the multiply stage as its y*_aggr operands for the output layer.

---
 rtl/gnn_aggr_xchg.sv | 129 ++++++++++++
 tb/tb_gnn_aggr_xchg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/gnn_aggr_xchg.sv
// Neighbourhood-aggregation exchange: collects per-node ReLU features, sums each
// node's own features with those of its neighbours, and streams the aggregates back.
module gnn_aggr_xchg #(
  parameter int NUM_NODES = 4,
  parameter int FEAT_W    = 15,
  parameter int AGGR_W    = 17
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [$clog2(NUM_NODES)-1:0] in_node_id,
  input  logic [FEAT_W-1:0]            in_y4,
  input  logic [FEAT_W-1:0]            in_y5,
  input  logic [FEAT_W-1:0]            in_y6,
  input  logic [FEAT_W-1:0]            in_y7,
  input  logic [NUM_NODES-1:0]         in_adj,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(NUM_NODES)-1:0] out_node_id,
  output logic [AGGR_W-1:0]            out_y4_aggr,
  output logic [AGGR_W-1:0]            out_y5_aggr,
  output logic [AGGR_W-1:0]            out_y6_aggr,
  output logic [AGGR_W-1:0]            out_y7_aggr,
  output logic                         busy
);

  localparam int ID_W    = $clog2(NUM_NODES);
  localparam int SUM_RAW = FEAT_W + ID_W + 1;
  localparam int SUM_W   = (SUM_RAW > AGGR_W) ? SUM_RAW : AGGR_W;
  localparam logic [AGGR_W-1:0] SAT_MAX = {1'b0, {(AGGR_W-1){1'b1}}};

  typedef enum logic [1:0] {S_COLLECT, S_AGGR, S_EMIT} state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [ID_W-1:0]      r_idx;
  logic [NUM_NODES-1:0] r_loaded;
  logic [FEAT_W-1:0]    r_feat [NUM_NODES][4];
  logic [NUM_NODES-1:0] r_adj  [NUM_NODES];
  logic [AGGR_W-1:0]    r_aggr [NUM_NODES][4];

  logic [FEAT_W-1:0]    w_in_feat [4];
  logic [SUM_W-1:0]     w_sum [4];
  logic [AGGR_W-1:0]    w_sat [4];
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_last_idx;
  logic [NUM_NODES-1:0] w_loaded_next;

  assign w_in_feat[0] = in_y4;
  assign w_in_feat[1] = in_y5;
  assign w_in_feat[2] = in_y6;
  assign w_in_feat[3] = in_y7;

  assign in_ready  = (r_state == S_COLLECT);
  assign out_valid = (r_state == S_EMIT);
  assign busy      = (r_state != S_COLLECT);

  assign w_in_fire     = in_valid & in_ready;
  assign w_out_fire    = out_valid & out_ready;
  assign w_last_idx    = (r_idx == ID_W'(NUM_NODES - 1));
  assign w_loaded_next = r_loaded | (NUM_NODES'(1) << in_node_id);

  // Data is forced to zero outside EMIT so the reset view is all-zero.
  assign out_node_id = out_valid ? r_idx : '0;
  assign out_y4_aggr = out_valid ? r_aggr[r_idx][0] : '0;
  assign out_y5_aggr = out_valid ? r_aggr[r_idx][1] : '0;
  assign out_y6_aggr = out_valid ? r_aggr[r_idx][2] : '0;
  assign out_y7_aggr = out_valid ? r_aggr[r_idx][3] : '0;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_COLLECT: if (w_in_fire && (&w_loaded_next)) w_next_state = S_AGGR;
      S_AGGR:    if (w_last_idx) w_next_state = S_EMIT;
      S_EMIT:    if (w_out_fire && w_last_idx) w_next_state = S_COLLECT;
      default:   w_next_state = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_COLLECT;
    else        r_state <= w_next_state;
  end

  // Index wraps to zero naturally because NUM_NODES is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_loaded <= '0;
    end else begin
      case (r_state)
        S_COLLECT: if (w_in_fire) r_loaded <= w_loaded_next;
        S_AGGR:    r_idx <= r_idx + 1'b1;
        S_EMIT: begin
          if (w_out_fire) begin
            r_idx <= r_idx + 1'b1;
            if (w_last_idx) r_loaded <= '0;
          end
        end
        default: r_idx <= '0;
      endcase
    end
  end

  // Self is always included; the diagonal adjacency bit is therefore irrelevant.
  always_comb begin
    for (int f = 0; f < 4; f++) begin
      w_sum[f] = '0;
      for (int j = 0; j < NUM_NODES; j++) begin
        if ((ID_W'(j) == r_idx) || r_adj[r_idx][j])
          w_sum[f] = w_sum[f] + SUM_W'(r_feat[j][f]);
      end
      w_sat[f] = (w_sum[f] > SUM_W'(SAT_MAX)) ? SAT_MAX : w_sum[f][AGGR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      for (int f = 0; f < 4; f++) r_feat[in_node_id][f] <= w_in_feat[f];
      r_adj[in_node_id] <= in_adj;
    end
    if (r_state == S_AGGR) begin
      for (int f = 0; f < 4; f++) r_aggr[r_idx][f] <= w_sat[f];
    end
  end

endmodule

// File: tb/tb_gnn_aggr_xchg.sv
// Directed, table-driven bench for gnn_aggr_xchg with hand-computed aggregates
// and hand-written sequences for back-pressure, duplicate ids and mid-frame reset.
module tb_gnn_aggr_xchg;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_node_id;
  logic [14:0] in_y4, in_y5, in_y6, in_y7;
  logic [3:0]  in_adj;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_node_id;
  logic [16:0] out_y4_aggr, out_y5_aggr, out_y6_aggr, out_y7_aggr;
  logic        busy;

  gnn_aggr_xchg #(.NUM_NODES(4), .FEAT_W(15), .AGGR_W(17)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_node_id(in_node_id),
    .in_y4(in_y4), .in_y5(in_y5), .in_y6(in_y6), .in_y7(in_y7), .in_adj(in_adj),
    .out_valid(out_valid), .out_ready(out_ready), .out_node_id(out_node_id),
    .out_y4_aggr(out_y4_aggr), .out_y5_aggr(out_y5_aggr),
    .out_y6_aggr(out_y6_aggr), .out_y7_aggr(out_y7_aggr),
    .busy(busy)
  );

  typedef struct packed {
    logic [3:0][3:0]       adj;
    logic [3:0][3:0][16:0] feat;
    logic [3:0][3:0][16:0] exp;
  } frame_t;

  frame_t frames [6];
  int     nChecks = 0;
  int     nErrors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkVal(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int aggrOf(input int f);
    case (f)
      0:       return int'(out_y4_aggr);
      1:       return int'(out_y5_aggr);
      2:       return int'(out_y6_aggr);
      default: return int'(out_y7_aggr);
    endcase
  endfunction

  task automatic sendBeat(input int id, input int f0, input int f1, input int f2,
                          input int f3, input logic [3:0] adj);
    in_valid   = 1'b1;
    in_node_id = 2'(id);
    in_y4 = 15'(f0); in_y5 = 15'(f1); in_y6 = 15'(f2); in_y7 = 15'(f3);
    in_adj = adj;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int fr);
    for (int n = 0; n < 4; n++) begin
      sendBeat(n, int'(frames[fr].feat[n][0]), int'(frames[fr].feat[n][1]),
               int'(frames[fr].feat[n][2]), int'(frames[fr].feat[n][3]),
               frames[fr].adj[n]);
      if (n < 3) begin
        checkVal($sformatf("f%0d busy after beat %0d", fr, n), int'(busy), 0);
        checkVal($sformatf("f%0d in_ready after beat %0d", fr, n), int'(in_ready), 1);
      end
    end
    checkVal($sformatf("f%0d busy in AGGR", fr), int'(busy), 1);
    checkVal($sformatf("f%0d in_ready in AGGR", fr), int'(in_ready), 0);
  endtask

  task automatic checkOutput(input int fr, input int stallNode, input bit timing);
    int cnt = 0;
    while (!out_valid && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    checkVal($sformatf("f%0d out_valid rise", fr), int'(out_valid), 1);
    if (timing) checkVal($sformatf("f%0d out_valid latency", fr), cnt, 4);
    for (int n = 0; n < 4; n++) begin
      checkVal($sformatf("f%0d valid node %0d", fr, n), int'(out_valid), 1);
      checkVal($sformatf("f%0d node_id %0d", fr, n), int'(out_node_id), n);
      for (int f = 0; f < 4; f++)
        checkVal($sformatf("f%0d node%0d aggr%0d", fr, n, f + 4), aggrOf(f),
                 int'(frames[fr].exp[n][f]));
      if (n == stallNode) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(posedge clk); #1;
          checkVal($sformatf("f%0d stall%0d valid", fr, s), int'(out_valid), 1);
          checkVal($sformatf("f%0d stall%0d node_id", fr, s), int'(out_node_id), n);
          checkVal($sformatf("f%0d stall%0d in_ready", fr, s), int'(in_ready), 0);
          for (int f = 0; f < 4; f++)
            checkVal($sformatf("f%0d stall%0d aggr%0d", fr, s, f + 4), aggrOf(f),
                     int'(frames[fr].exp[n][f]));
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    checkVal($sformatf("f%0d in_ready after emit", fr), int'(in_ready), 1);
    checkVal($sformatf("f%0d out_valid after emit", fr), int'(out_valid), 0);
    checkVal($sformatf("f%0d busy after emit", fr), int'(busy), 0);
  endtask

  initial begin
    int cnt;
    // 0 ring, 1 zero adjacency, 2 fully connected, 3 self bits only, 4 asymmetric, 5 duplicate-id ring
    for (int n = 0; n < 4; n++) begin
      for (int f = 0; f < 4; f++) begin
        frames[0].feat[n][f] = 17'(10 * n + f + 1);
        frames[1].feat[n][f] = 17'(16383);
        frames[1].exp[n][f]  = 17'(16383);
        frames[2].feat[n][f] = 17'(16383);
        frames[2].exp[n][f]  = 17'(65532);
        frames[3].feat[n][f] = 17'(10 * n + f + 1);
        frames[3].exp[n][f]  = 17'(10 * n + f + 1);
        frames[4].feat[n][f] = 17'(10 * n + f + 1);
        frames[4].exp[n][f]  = (n == 0) ? 17'(64 + 4 * f) : 17'(10 * n + f + 1);
        frames[5].feat[n][f] = 17'(10 * n + f + 1);
      end
    end
    frames[0].adj = {4'b0101, 4'b1010, 4'b0101, 4'b1010};
    frames[1].adj = '0;
    frames[2].adj = {4'b1111, 4'b1111, 4'b1111, 4'b1111};
    frames[3].adj = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    frames[4].adj = {4'b0000, 4'b0000, 4'b0000, 4'b1110};
    frames[5].adj = frames[0].adj;
    for (int f = 0; f < 4; f++) begin
      frames[0].exp[0][f] = 17'(43 + 3 * f);
      frames[0].exp[1][f] = 17'(33 + 3 * f);
      frames[0].exp[2][f] = 17'(63 + 3 * f);
      frames[0].exp[3][f] = 17'(53 + 3 * f);
    end
    frames[5].exp = frames[0].exp;
    frames[5].feat[1][0] = 17'(9);
    frames[5].exp[0][0]  = 17'(41);
    frames[5].exp[1][0]  = 17'(31);
    frames[5].exp[2][0]  = 17'(61);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_node_id = '0; in_y4 = '0; in_y5 = '0; in_y6 = '0; in_y7 = '0; in_adj = '0;
    #12;
    checkVal("reset in_ready", int'(in_ready), 1);
    checkVal("reset out_valid", int'(out_valid), 0);
    checkVal("reset busy", int'(busy), 0);
    checkVal("reset out_node_id", int'(out_node_id), 0);
    for (int f = 0; f < 4; f++) checkVal($sformatf("reset aggr%0d", f + 4), aggrOf(f), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int fr = 0; fr < 4; fr++) begin
      applyStimulus(fr);
      checkOutput(fr, (fr == 2) ? 2 : -1, 1'b1);
    end

    $display("[TB] duplicate node_id sequence");
    sendBeat(0, 1, 2, 3, 4, frames[5].adj[0]);
    sendBeat(1, 5, 12, 13, 14, frames[5].adj[1]);
    sendBeat(2, 21, 22, 23, 24, frames[5].adj[2]);
    sendBeat(1, 9, 12, 13, 14, frames[5].adj[1]);
    checkVal("dup busy before last id", int'(busy), 0);
    checkVal("dup in_ready before last id", int'(in_ready), 1);
    sendBeat(3, 31, 32, 33, 34, frames[5].adj[3]);
    checkVal("dup busy after last id", int'(busy), 1);
    checkOutput(5, -1, 1'b1);

    $display("[TB] reset during EMIT");
    applyStimulus(4);
    cnt = 0;
    while (!out_valid && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    checkVal("rst-seq out_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    checkVal("rst-seq at node 1", int'(out_node_id), 1);
    #2 rst_n = 1'b0;
    #1;
    checkVal("async rst out_valid", int'(out_valid), 0);
    checkVal("async rst in_ready", int'(in_ready), 1);
    checkVal("async rst busy", int'(busy), 0);
    checkVal("async rst out_node_id", int'(out_node_id), 0);
    for (int f = 0; f < 4; f++) checkVal($sformatf("async rst aggr%0d", f + 4), aggrOf(f), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(4);
    checkOutput(4, -1, 1'b1);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
